cla_pipe_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group.sv | 32 +++
 rtl/cla_pipe_adder.sv | 137 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GRP = 4;

  typedef struct packed {
    logic [GRP-1:0] g;
    logic [GRP-1:0] p;
  } gp_t;

  function automatic int stages_of(input int width);
    return width / GRP;
  endfunction

  function automatic gp_t gp_of(input logic [GRP-1:0] a, input logic [GRP-1:0] b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational 4-bit carry-lookahead group with every carry expanded to
// sum-of-products form, so no carry ripples through another inside the group.
module cla_group
  import cla_pkg::*;
(
  input  logic [GRP-1:0] a,
  input  logic [GRP-1:0] b,
  input  logic           c_in,
  output logic [GRP-1:0] s,
  output logic           c_out,
  output logic           c_msb_in
);

  gp_t         gp;
  logic [GRP:0] c;

  always_comb begin
    gp   = gp_of(a, b);
    c[0] = c_in;
    c[1] = gp.g[0] | (gp.p[0] & c_in);
    c[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & c_in);
    c[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
         | (gp.p[2] & gp.p[1] & gp.p[0] & c_in);
    c[4] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
         | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
         | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & c_in);
    s        = gp.p ^ c[GRP-1:0];
    c_out    = c[GRP];
    c_msb_in = c[GRP-1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one 4-bit lookahead group per stage, registered
// inter-group carry, operands skewed forward and low sum bits carried along.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stages_of(WIDTH);
  localparam int RANKS  = (STAGES > 1) ? STAGES - 1 : 1;

  logic adv;

  logic [STAGES-1:0] vld_d, vld_q;

  logic [WIDTH-1:0] a_d   [RANKS];
  logic [WIDTH-1:0] a_q   [RANKS];
  logic [WIDTH-1:0] b_d   [RANKS];
  logic [WIDTH-1:0] b_q   [RANKS];
  logic [WIDTH-1:0] sum_d [RANKS];
  logic [WIDTH-1:0] sum_q [RANKS];
  logic             c_d   [RANKS];
  logic             c_q   [RANKS];

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  logic [WIDTH-1:0] stg_a  [STAGES];
  logic [WIDTH-1:0] stg_b  [STAGES];
  logic [WIDTH-1:0] stg_lo [STAGES];
  logic             stg_c  [STAGES];
  logic [GRP-1:0]   grp_s  [STAGES];
  logic             grp_co [STAGES];
  logic             grp_cm [STAGES];

  // Stage 0 takes the raw operands; subtraction is a + ~b + 1.
  always_comb begin
    stg_a[0]  = a;
    stg_b[0]  = sub ? ~b : b;
    stg_c[0]  = sub | cin;
    stg_lo[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      stg_a[k]  = a_q[k-1];
      stg_b[k]  = b_q[k-1];
      stg_c[k]  = c_q[k-1];
      stg_lo[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_group u_grp (
      .a        (stg_a[k][GRP*k +: GRP]),
      .b        (stg_b[k][GRP*k +: GRP]),
      .c_in     (stg_c[k]),
      .s        (grp_s[k]),
      .c_out    (grp_co[k]),
      .c_msb_in (grp_cm[k])
    );
  end

  // One shared advance: the whole pipe moves or the whole pipe holds.
  always_comb begin
    adv      = !vld_q[STAGES-1] || out_ready;
    vld_d    = vld_q;
    s_d      = s_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    for (int k = 0; k < STAGES - 1; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      c_d[k]   = c_q[k];
      sum_d[k] = sum_q[k];
    end
    if (adv) begin
      vld_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_d[k]   = stg_a[k];
        b_d[k]   = stg_b[k];
        c_d[k]   = grp_co[k];
        sum_d[k] = stg_lo[k];
        sum_d[k][GRP*k +: GRP] = grp_s[k];
      end
      s_d = stg_lo[STAGES-1];
      s_d[GRP*(STAGES-1) +: GRP] = grp_s[STAGES-1];
      cout_d = grp_co[STAGES-1];
      ovf_d  = grp_co[STAGES-1] ^ grp_cm[STAGES-1];
    end
  end

  // Valid chain and the visible result rank clear on reset; skew data does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    c_q   <= c_d;
    sum_q <= sum_d;
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=16): directed corner cases,
// back-pressure, reset with beats in flight, then a long random stream.
module tb_cla_pipe_adder;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } res_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  cla_pipe_adder #(.WIDTH(WIDTH), .GRP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  res_t sb_q[$];

  logic             last_out_valid;
  logic             last_in_ready;
  logic             last_accept;
  logic             held;
  logic [WIDTH-1:0] held_s;
  logic             held_c;
  logic             held_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic sb);
    res_t             r;
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   full;
    yy   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (sb ? {{WIDTH{1'b0}}, 1'b1} : {{WIDTH{1'b0}}, ci});
    r.s  = full[WIDTH-1:0];
    r.c  = full[WIDTH];
    r.o  = (x[WIDTH-1] == yy[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  // One clock: drive at negedge, then score what the next rising edge will do.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                       input logic ci, input logic sb, input logic ordy);
    res_t e;
    @(negedge clk);
    in_valid  = v;
    a         = opa;
    b         = opb;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    last_out_valid = out_valid;
    last_in_ready  = in_ready;
    last_accept    = v && in_ready;
    if (held) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_s", {16'd0, s}, {16'd0, held_s});
      check("hold_cout_ovf", {30'd0, cout, ovf}, {30'd0, held_c, held_o});
    end
    held = out_valid && !ordy;
    if (held) begin
      held_s = s;
      held_c = cout;
      held_o = ovf;
    end
    if (last_accept) sb_q.push_back(model(opa, opb, ci, sb));
    if (out_valid && ordy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("s", {16'd0, s}, {16'd0, e.s});
        check("cout", {31'd0, cout}, {31'd0, e.c});
        check("ovf", {31'd0, ovf}, {31'd0, e.o});
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  // Single beat into an empty pipe; count cycles until the result shows.
  task automatic one_beat(input string tag, input logic [WIDTH-1:0] opa,
                          input logic [WIDTH-1:0] opb, input logic ci, input logic sb);
    int lat;
    cycle(1'b1, opa, opb, ci, sb, 1'b1);
    check({tag, "_accept"}, {31'd0, last_accept}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      idle(1'b1);
      if (last_out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd4);
  endtask

  initial begin
    int sent;
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    held      = 1'b0;

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    check("post_rst_in_ready", {31'd0, last_in_ready}, 32'd1);

    one_beat("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0);
    one_beat("sovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0);
    one_beat("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1);
    one_beat("chain",     16'h0FFF, 16'h0000, 1'b1, 1'b0);
    one_beat("sub_cin",   16'h8000, 16'h0001, 1'b1, 1'b1);
    one_beat("full_cin",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // Eight back-to-back beats with out_ready low for three cycles mid-stream.
    sent = 0;
    for (cyc = 0; cyc < 40 && (sent < 8 || sb_q.size() != 0); cyc++) begin
      logic ordy;
      logic [WIDTH-1:0] opa;
      logic [WIDTH-1:0] opb;
      ordy = !(cyc >= 5 && cyc <= 7);
      opa  = 16'h1111 * (sent + 1);
      opb  = 16'h0F0F + 16'(sent * 16'h0123);
      cycle(sent < 8, opa, opb, sent[0], (sent % 3) == 2, ordy);
      if (cyc >= 5 && cyc <= 7) check("stall_in_ready", {31'd0, last_in_ready}, 32'd0);
      if (last_accept) sent++;
    end
    check("stream_sent", sent, 32'd8);
    check("stream_drained", sb_q.size(), 32'd0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h4000 + 16'(i), 16'h4000, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_s", {16'd0, s}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    held = 1'b0;
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check("no_stale", {31'd0, last_out_valid}, 32'd0);
    end
    one_beat("after_rst", 16'h1234, 16'h4321, 1'b1, 1'b0);

    // Random traffic with random bubbles and back-pressure.
    sent = 0;
    for (cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      logic v;
      logic ordy;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      cycle(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
      if (last_accept) sent++;
    end
    check("random_sent", sent, 32'd10000);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) idle(1'b1);
    check("final_drain", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
